uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares the single UART byte transmitter (`uart_tx`) between `NUM_REQ` byte-stream requesters. Each requester presents bytes with a valid/ready handshake and may hold ownership for a packet of up to `MAX_BURST` bytes. The block sequences one `tx_en` pulse per byte and waits for the transmitter's done pulse before loading the next byte. It sits between the requesters and `uart_tx`, beside `uart_core`.

---
 rtl/uart_arb_pkg.sv | 14 +
 rtl/uart_rr_pick.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART TX/RX arbitration blocks.
package uart_arb_pkg;

  localparam int unsigned DefNumReq   = 4;
  localparam int unsigned DefMaxBurst = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_LOAD,
    ARB_START,
    ARB_WAIT
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority picker: first set request above last_ptr_i, wrapping around.
module uart_rr_pick #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   last_ptr_i,
  output logic [NumReq-1:0] pick_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              any_o
);

  logic [IdxW-1:0] w_idx;

  // Scan from the farthest candidate down to the nearest so the nearest valid one wins.
  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    w_idx  = '0;
    for (int i = int'(NumReq); i >= 1; i--) begin
      w_idx = IdxW'((int'(last_ptr_i) + i) % int'(NumReq));
      if (req_i[w_idx]) begin
        pick_o        = '0;
        pick_o[w_idx] = 1'b1;
        idx_o         = w_idx;
        any_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the shared uart_tx: one byte per tx_en pulse, bursts up to MAX_BURST.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DefNumReq,
  parameter int unsigned MAX_BURST = DefMaxBurst
) (
  input  logic                 pclk_i,
  input  logic                 prst_ni,
  input  logic                 enable_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 tx_en_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_done_i,
  output logic                 busy_o,
  output logic [15:0]          byte_cnt_o
);

  localparam int unsigned IdxW   = $clog2(NUM_REQ);
  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_BURST);

  arb_state_e          r_state, w_state_next;
  logic [NUM_REQ-1:0]  r_grant;
  logic [IdxW-1:0]     r_gidx;
  logic [IdxW-1:0]     r_last_ptr;
  logic [BurstW-1:0]   r_burst_cnt;
  logic                r_last;
  logic [7:0]          r_tx_data;
  logic [15:0]         r_byte_cnt;
  logic [NUM_REQ-1:0]  r_ready;
  logic                r_tx_en;

  logic [NUM_REQ-1:0]  w_pick;
  logic [IdxW-1:0]     w_pick_idx;
  logic                w_pick_any;
  logic [7:0]          w_g_data;
  logic                w_g_last;
  logic                w_take;
  logic                w_release;
  logic [NUM_REQ-1:0]  w_ready_d;
  logic                w_tx_en_d;

  uart_rr_pick #(
    .NumReq (NUM_REQ),
    .IdxW   (IdxW)
  ) u_pick (
    .req_i      (req_valid_i),
    .last_ptr_i (r_last_ptr),
    .pick_o     (w_pick),
    .idx_o      (w_pick_idx),
    .any_o      (w_pick_any)
  );

  // Owner's lane, selected by the one-hot grant.
  always_comb begin
    w_g_data = '0;
    w_g_last = 1'b0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (r_grant[r]) begin
        w_g_data = req_data_i[8*r +: 8];
        w_g_last = req_last_i[r];
      end
    end
  end

  // Ready is registered ahead of LOAD, so a transfer needs both sides high in LOAD.
  assign w_take    = |(r_ready & req_valid_i & r_grant);
  assign w_release = r_last || (r_burst_cnt == BurstMax) || !enable_i;

  always_ff @(posedge pclk_i or negedge prst_ni) begin
    if (!prst_ni) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ARB_IDLE:  if (enable_i && w_pick_any) w_state_next = ARB_LOAD;
      ARB_LOAD:  w_state_next = w_take ? ARB_START : ARB_IDLE;
      ARB_START: w_state_next = ARB_WAIT;
      ARB_WAIT:  if (tx_done_i) w_state_next = w_release ? ARB_IDLE : ARB_LOAD;
      default:   w_state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    w_ready_d = '0;
    w_tx_en_d = 1'b0;
    unique case (r_state)
      ARB_IDLE:  if (w_state_next == ARB_LOAD) w_ready_d = w_pick;
      ARB_LOAD:  w_tx_en_d = w_take;
      ARB_WAIT:  if (w_state_next == ARB_LOAD) w_ready_d = r_grant & req_valid_i;
      default:   ;
    endcase
  end

  always_ff @(posedge pclk_i or negedge prst_ni) begin
    if (!prst_ni) begin
      r_grant     <= '0;
      r_gidx      <= '0;
      r_last_ptr  <= IdxW'(NUM_REQ - 1);
      r_burst_cnt <= '0;
      r_last      <= 1'b0;
      r_tx_data   <= '0;
      r_byte_cnt  <= '0;
      r_ready     <= '0;
      r_tx_en     <= 1'b0;
    end else begin
      r_ready <= w_ready_d;
      r_tx_en <= w_tx_en_d;
      unique case (r_state)
        ARB_IDLE: begin
          if (w_state_next == ARB_LOAD) begin
            r_grant     <= w_pick;
            r_gidx      <= w_pick_idx;
            r_burst_cnt <= '0;
          end
        end
        ARB_LOAD: begin
          if (w_take) begin
            r_tx_data   <= w_g_data;
            r_last      <= w_g_last;
            r_burst_cnt <= r_burst_cnt + 1'b1;
          end else begin
            r_last_ptr <= r_gidx;
            r_grant    <= '0;
          end
        end
        ARB_START: r_byte_cnt <= r_byte_cnt + 16'd1;
        ARB_WAIT: begin
          if (tx_done_i && w_release) begin
            r_last_ptr <= r_gidx;
            r_grant    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o = r_ready;
  assign grant_o     = r_grant;
  assign tx_en_o     = r_tx_en;
  assign tx_data_o   = r_tx_data;
  assign busy_o      = (r_state != ARB_IDLE);
  assign byte_cnt_o  = r_byte_cnt;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle table for the single-request latency, scoreboard for ordering.
module tb_uart_tx_arbiter;

  localparam int NR    = 4;
  localparam int Frame = 3;

  logic            pclk_i = 1'b0;
  logic            prst_ni;
  logic            enable_i;
  logic [NR-1:0]   req_valid_i;
  logic [NR*8-1:0] req_data_i;
  logic [NR-1:0]   req_last_i;
  logic [NR-1:0]   req_ready_o;
  logic [NR-1:0]   grant_o;
  logic            tx_en_o;
  logic [7:0]      tx_data_o;
  logic            tx_done_i;
  logic            busy_o;
  logic [15:0]     byte_cnt_o;

  uart_tx_arbiter #(
    .NUM_REQ   (NR),
    .MAX_BURST (4)
  ) dut (
    .pclk_i      (pclk_i),
    .prst_ni     (prst_ni),
    .enable_i    (enable_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .grant_o     (grant_o),
    .tx_en_o     (tx_en_o),
    .tx_data_o   (tx_data_o),
    .tx_done_i   (tx_done_i),
    .busy_o      (busy_o),
    .byte_cnt_o  (byte_cnt_o)
  );

  always #5 pclk_i = ~pclk_i;

  typedef struct packed {
    logic [1:0] req;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [3:0]  valid;
    logic [7:0]  data;
    logic        last;
    logic        done;
    logic [3:0]  grant;
    logic [3:0]  ready;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        busy;
    logic [15:0] cnt;
  } vec_t;

  int          n_run = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];
  logic [8:0]  src_q[NR][$];
  logic [NR-1:0] pend;
  int          tx_cnt;
  logic        seen_tx_en;
  vec_t        vec[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_run++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int r = 0; r < NR; r++) src_q[r].delete();
    pend        = '0;
    tx_cnt      = 0;
    tx_done_i   = 1'b0;
    req_valid_i = '0;
    req_data_i  = '0;
    req_last_i  = '0;
  endtask

  task automatic do_reset();
    prst_ni  = 1'b0;
    enable_i = 1'b1;
    clear_model();
    repeat (2) @(negedge pclk_i);
    prst_ni = 1'b1;
  endtask

  task automatic push_src(input int r, input logic [7:0] d, input logic last);
    src_q[r].push_back({last, d});
  endtask

  task automatic push_exp(input int r, input logic [7:0] d);
    exp_t e;
    e.req  = 2'(r);
    e.data = d;
    exp_q.push_back(e);
  endtask

  // One clock of requester + transmitter models, evaluated at the falling edge.
  task automatic cycle();
    exp_t       e;
    logic [3:0] oh;
    @(negedge pclk_i);
    for (int r = 0; r < NR; r++) if (pend[r]) void'(src_q[r].pop_front());
    seen_tx_en = tx_en_o;
    if (tx_en_o) begin
      if (exp_q.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL unexpected_tx_en: got grant=%b data=%h, required no transfer",
                 grant_o, tx_data_o);
      end else begin
        e  = exp_q.pop_front();
        oh = 4'b0001 << e.req;
        check("tx_byte grant/data", {grant_o, tx_data_o}, {oh, e.data});
      end
    end
    tx_done_i = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_done_i = 1'b1;
    end
    if (seen_tx_en) tx_cnt = Frame;
    for (int r = 0; r < NR; r++) begin
      req_valid_i[r] = (src_q[r].size() > 0);
      req_data_i[8*r +: 8] = (src_q[r].size() > 0) ? src_q[r][0][7:0] : 8'h00;
      req_last_i[r] = (src_q[r].size() > 0) ? src_q[r][0][8] : 1'b0;
    end
    pend = req_ready_o & req_valid_i;
  endtask

  task automatic run_idle(input string name, input int budget);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!(exp_q.size() == 0 && !busy_o && tx_cnt == 0) && n < budget);
    if (!(exp_q.size() == 0 && !busy_o && tx_cnt == 0)) begin
      n_run++;
      n_fail++;
      $display("FAIL %s timeout: got %0d bytes still expected busy=%b, required idle",
               name, exp_q.size(), busy_o);
    end
  endtask

  initial begin
    // {valid, data, last, done} -> {grant, ready, tx_en, tx_data, busy, byte_cnt} after the edge
    vec[0] = '{4'b0100, 8'hA5, 1'b1, 1'b0, 4'b0100, 4'b0100, 1'b0, 8'h00, 1'b1, 16'd0};
    vec[1] = '{4'b0100, 8'hA5, 1'b1, 1'b0, 4'b0100, 4'b0000, 1'b1, 8'hA5, 1'b1, 16'd0};
    vec[2] = '{4'b0000, 8'h00, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 8'hA5, 1'b1, 16'd1};
    vec[3] = '{4'b0000, 8'h00, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 8'hA5, 1'b1, 16'd1};
    vec[4] = '{4'b0000, 8'h00, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'hA5, 1'b0, 16'd1};
    vec[5] = '{4'b0000, 8'h00, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'hA5, 1'b0, 16'd1};

    do_reset();
    check("reset grant", grant_o, 4'b0);
    check("reset ready", req_ready_o, 4'b0);
    check("reset tx_en", tx_en_o, 1'b0);
    check("reset tx_data", tx_data_o, 8'h00);
    check("reset busy", busy_o, 1'b0);
    check("reset byte_cnt", byte_cnt_o, 16'd0);

    // Single request on requester 2, cycle by cycle.
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk_i);
      req_valid_i = vec[i].valid;
      req_data_i  = {4{vec[i].data}};
      req_last_i  = {4{vec[i].last}};
      tx_done_i   = vec[i].done;
      @(posedge pclk_i);
      #1;
      check($sformatf("single_req step %0d", i),
            {grant_o, req_ready_o, tx_en_o, tx_data_o, busy_o, byte_cnt_o},
            {vec[i].grant, vec[i].ready, vec[i].tx_en, vec[i].tx_data, vec[i].busy, vec[i].cnt});
    end

    // Round-robin over requesters 0, 1, 3.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      push_src(0, 8'(8'h01 + k), 1'b1);
      push_src(1, 8'(8'h11 + k), 1'b1);
      push_src(3, 8'(8'h31 + k), 1'b1);
    end
    for (int k = 0; k < 2; k++) begin
      push_exp(0, 8'(8'h01 + k));
      push_exp(1, 8'(8'h11 + k));
      push_exp(3, 8'(8'h31 + k));
    end
    run_idle("round_robin", 300);
    check("round_robin byte_cnt", byte_cnt_o, 16'd6);
    check("round_robin grant idle", grant_o, 4'b0);

    // Burst limit: requester 1 streams 6, requester 2 waits with one byte.
    do_reset();
    for (int k = 0; k < 6; k++) push_src(1, 8'(8'h40 + k), 1'b0);
    push_src(2, 8'h77, 1'b1);
    for (int k = 0; k < 4; k++) push_exp(1, 8'(8'h40 + k));
    push_exp(2, 8'h77);
    push_exp(1, 8'h44);
    push_exp(1, 8'h45);
    run_idle("burst_limit", 400);
    check("burst_limit byte_cnt", byte_cnt_o, 16'd7);

    // Valid drops before the second LOAD.
    do_reset();
    push_src(0, 8'h5A, 1'b0);
    push_exp(0, 8'h5A);
    run_idle("valid_drop", 200);
    check("valid_drop byte_cnt", byte_cnt_o, 16'd1);
    check("valid_drop busy", busy_o, 1'b0);
    push_src(0, 8'h5B, 1'b1);
    push_src(1, 8'h6B, 1'b1);
    push_exp(1, 8'h6B);
    push_exp(0, 8'h5B);
    run_idle("valid_drop rr", 200);
    check("valid_drop rr byte_cnt", byte_cnt_o, 16'd3);

    // Enable low while the first byte is in flight.
    do_reset();
    for (int k = 0; k < 4; k++) push_src(3, 8'(8'hC0 + k), k == 3);
    push_exp(3, 8'hC0);
    begin
      int n = 0;
      do begin
        cycle();
        n++;
      end while (!seen_tx_en && n < 50);
      check("enable_low saw tx_en", seen_tx_en, 1'b1);
    end
    enable_i = 1'b0;
    run_idle("enable_low", 200);
    check("enable_low byte_cnt", byte_cnt_o, 16'd1);
    check("enable_low bytes left", 32'(src_q[3].size()), 32'd3);
    check("enable_low busy", busy_o, 1'b0);
    enable_i = 1'b1;
    for (int k = 1; k < 4; k++) push_exp(3, 8'(8'hC0 + k));
    run_idle("enable_resume", 300);
    check("enable_resume byte_cnt", byte_cnt_o, 16'd4);

    // Asynchronous reset during WAIT.
    do_reset();
    push_src(2, 8'h5C, 1'b1);
    push_exp(2, 8'h5C);
    begin
      int n = 0;
      do begin
        cycle();
        n++;
      end while (!seen_tx_en && n < 50);
      check("reset_wait saw tx_en", seen_tx_en, 1'b1);
    end
    cycle();
    check("reset_wait in WAIT busy", busy_o, 1'b1);
    #2;
    prst_ni = 1'b0;
    #1;
    check("reset_wait async outputs",
          {grant_o, req_ready_o, tx_en_o, tx_data_o, busy_o, byte_cnt_o},
          {4'b0, 4'b0, 1'b0, 8'h00, 1'b0, 16'd0});
    clear_model();
    @(negedge pclk_i);
    prst_ni = 1'b1;
    push_src(0, 8'h0E, 1'b1);
    push_src(2, 8'h2E, 1'b1);
    push_exp(0, 8'h0E);
    push_exp(2, 8'h2E);
    run_idle("reset_wait after", 200);
    check("reset_wait after byte_cnt", byte_cnt_o, 16'd2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
